// File: rtl/comple2_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// comple2_seq_ctrl_if
//   Bundle of the request, result and complement-unit signals for
//   comple2_seq_ctrl. W = 16*NWORDS.
//   Ports (as seen from the sequencer, modport slave):
//     req0_valid/req0_data/req0_neg  in   requester 0 operand and negate select
//     req0_ready                     out  requester 0 accepted this cycle
//     req1_*                         same for requester 1
//     out_valid/out_data/out_id/out_co/out_ovf  out  result and flags
//     out_ready                      in   consumer takes result
//     busy                           out  sequencer not idle
//     cu_a/cu_cin/cu_cmp             out  word, carry-in, complement select to the unit
//     cu_r/cu_co                     in   unit result and carry-out
//   modport master is the environment view (requesters, consumer, unit).
// ---------------------------------------------------------------------------
interface comple2_seq_ctrl_if #(
    parameter int NWORDS = 4
);
    localparam int W = 16 * NWORDS;

    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_data;
    logic         req0_neg;
    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_data;
    logic         req1_neg;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_id;
    logic         out_co;
    logic         out_ovf;
    logic         busy;
    logic [15:0]  cu_a;
    logic         cu_cin;
    logic         cu_cmp;
    logic [15:0]  cu_r;
    logic         cu_co;

    modport master (
        output req0_valid, req0_data, req0_neg,
        output req1_valid, req1_data, req1_neg,
        output out_ready, cu_r, cu_co,
        input  req0_ready, req1_ready,
        input  out_valid, out_data, out_id, out_co, out_ovf, busy,
        input  cu_a, cu_cin, cu_cmp
    );

    modport slave (
        input  req0_valid, req0_data, req0_neg,
        input  req1_valid, req1_data, req1_neg,
        input  out_ready, cu_r, cu_co,
        output req0_ready, req1_ready,
        output out_valid, out_data, out_id, out_co, out_ovf, busy,
        output cu_a, cu_cin, cu_cmp
    );
endinterface

// File: rtl/comple2_seq_ctrl.sv
// ---------------------------------------------------------------------------
// comple2_seq_ctrl
//   Multi-word two's-complement sequencer and 2-port arbiter in front of the
//   shared combinational 16-bit complement unit. An accepted operand is fed
//   to the unit one word per cycle, LSW first, with the unit's carry-out
//   chained into the next word's carry-in. The full result is then held with
//   the final carry and an overflow flag (negation of the most-negative value)
//   until the consumer takes it.
//   Ports:
//     clk   in   single clock, rising edge
//     rst   in   synchronous reset, active-high
//     bus   slave view of comple2_seq_ctrl_if (requests, result, unit link)
// ---------------------------------------------------------------------------
module comple2_seq_ctrl #(
    parameter int NWORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    comple2_seq_ctrl_if.slave   bus
);
    localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                   state, state_nx;
    logic [NWORDS-1:0][15:0]  op_q;
    logic [NWORDS-1:0][15:0]  res_q;
    logic                     neg_q;
    logic                     id_q;
    logic                     carry_q;
    logic [IW-1:0]            idx_q;
    logic                     rr_last;
    logic                     rr_vld;
    logic                     grant0;
    logic                     grant1;
    logic                     accept;
    logic                     last_word;

    // rr_last is the requester served last; rr_vld stays low until the first
    // result is delivered so that req0 wins the first contested grant.
    always_comb begin
        grant0 = bus.req0_valid & (~bus.req1_valid | ~rr_vld | rr_last);
        grant1 = bus.req1_valid & (~bus.req0_valid | (rr_vld & ~rr_last));
    end

    assign accept    = (state == IDLE) & (grant0 | grant1);
    assign last_word = (idx_q == IW'(NWORDS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept)        state_nx = RUN;
            RUN:  if (last_word)     state_nx = DONE;
            DONE: if (bus.out_ready) state_nx = IDLE;
            default:                 state_nx = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            res_q   <= '0;
            neg_q   <= 1'b0;
            id_q    <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            rr_last <= 1'b0;
            rr_vld  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q    <= grant0 ? bus.req0_data : bus.req1_data;
                        neg_q   <= grant0 ? bus.req0_neg  : bus.req1_neg;
                        carry_q <= grant0 ? bus.req0_neg  : bus.req1_neg;
                        id_q    <= grant1;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    res_q[idx_q] <= bus.cu_r;
                    carry_q      <= bus.cu_co;
                    idx_q        <= idx_q + IW'(1);
                end
                DONE: begin
                    if (bus.out_ready) begin
                        rr_last <= id_q;
                        rr_vld  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: result fields are forced to zero unless a result is presented.
    always_comb begin
        bus.req0_ready = (state == IDLE) & grant0;
        bus.req1_ready = (state == IDLE) & grant1;
        bus.busy       = (state != IDLE);
        bus.out_valid  = 1'b0;
        bus.out_data   = '0;
        bus.out_id     = 1'b0;
        bus.out_co     = 1'b0;
        bus.out_ovf    = 1'b0;
        bus.cu_a       = '0;
        bus.cu_cin     = 1'b0;
        bus.cu_cmp     = 1'b0;
        if (state == RUN) begin
            bus.cu_a   = op_q[idx_q];
            bus.cu_cin = carry_q;
            bus.cu_cmp = neg_q;
        end
        if (state == DONE) begin
            bus.out_valid = 1'b1;
            bus.out_data  = res_q;
            bus.out_id    = id_q;
            bus.out_co    = carry_q;
            bus.out_ovf   = neg_q & op_q[NWORDS-1][15] & res_q[NWORDS-1][15];
        end
    end

endmodule

// File: tb/tb_comple2_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_comple2_seq_ctrl
//   Scoreboard bench for comple2_seq_ctrl with NWORDS=4. A combinational
//   model of the complement unit closes the cu_* loop. Accepted operands are
//   turned into expected results with whole-width arithmetic and queued; a
//   monitor compares unit traffic, busy and the result interface against the
//   queue head every cycle.
// ---------------------------------------------------------------------------
module tb_comple2_seq_ctrl;
    localparam int NW = 4;
    localparam int W  = 16 * NW;

    typedef struct {
        logic [W-1:0] op;
        logic         neg;
    } stim_t;

    typedef struct {
        logic [W-1:0] op;
        logic         neg;
        logic         id;
        int           acc;
        logic [W-1:0] res;
        logic         co;
        logic         ovf;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    comple2_seq_ctrl_if #(.NWORDS(NW)) bif();

    comple2_seq_ctrl #(.NWORDS(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    // complement unit: R = (A ^ {16{cmp}}) + Cin
    logic [16:0] cu_sum;
    assign cu_sum     = {1'b0, bif.cu_a ^ {16{bif.cu_cmp}}} + {16'd0, bif.cu_cin};
    assign bif.cu_r   = cu_sum[15:0];
    assign bif.cu_co  = cu_sum[16];

    logic         v0 = 1'b0, v1 = 1'b0, n0 = 1'b0, n1 = 1'b0, ordy = 1'b0;
    logic [W-1:0] d0 = '0, d1 = '0;
    assign bif.req0_valid = v0;
    assign bif.req0_data  = d0;
    assign bif.req0_neg   = n0;
    assign bif.req1_valid = v1;
    assign bif.req1_data  = d1;
    assign bif.req1_neg   = n1;
    assign bif.out_ready  = ordy;

    stim_t q0[$];
    stim_t q1[$];
    item_t sb[$];
    int errors  = 0;
    int checks  = 0;
    int cyc     = 0;
    int last_id = -1;
    int rdy_mode = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: whole-width two's complement, carry is bit W of ~op+1.
    function automatic item_t model(input logic [W-1:0] op, input logic neg, input logic id, input int acc);
        logic [W:0] s;
        item_t      it;
        s      = neg ? ({1'b0, ~op} + {{W{1'b0}}, 1'b1}) : {1'b0, op};
        it.op  = op;
        it.neg = neg;
        it.id  = id;
        it.acc = acc;
        it.res = s[W-1:0];
        it.co  = s[W];
        it.ovf = neg & op[W-1] & s[W-1];
        return it;
    endfunction

    // Carry into word k of ~op+1 is set exactly when every lower bit of op is 0.
    function automatic logic cin_exp(input logic [W-1:0] op, input logic neg, input int k);
        logic [W-1:0] mask;
        mask = (64'd1 << (16 * k)) - 64'd1;
        return neg & ((op & mask) == '0);
    endfunction

    // out_ready driver
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       ordy = 1'b0;
            1:       ordy = 1'b1;
            default: ordy = 1'($urandom_range(0, 1));
        endcase
    end

    // Requester drivers: hold valid until accepted, then load the next operand
    // (or scramble data with valid low to show it is ignored).
    initial begin
        logic  a0, a1;
        stim_t s;
        forever begin
            @(negedge clk);
            a0 = !rst && v0 && bif.req0_ready;
            a1 = !rst && v1 && bif.req1_ready;
            @(posedge clk);
            #1;
            if (a0 || !v0) begin
                if (q0.size() > 0) begin
                    s = q0.pop_front(); v0 = 1'b1; d0 = s.op; n0 = s.neg;
                end else begin
                    v0 = 1'b0; d0 = {$urandom, $urandom}; n0 = 1'($urandom);
                end
            end
            if (a1 || !v1) begin
                if (q1.size() > 0) begin
                    s = q1.pop_front(); v1 = 1'b1; d1 = s.op; n1 = s.neg;
                end else begin
                    v1 = 1'b0; d1 = {$urandom, $urandom}; n1 = 1'($urandom);
                end
            end
        end
    end

    // Grant check and scoreboard push on every acceptance.
    always @(negedge clk) begin
        logic e0, e1;
        int   win;
        if (!rst) begin
            if (v0 || v1 || bif.req0_ready || bif.req1_ready) begin
                e0 = 1'b0;
                e1 = 1'b0;
                if (sb.size() == 0) begin
                    if (v0 && v1) win = (last_id == 0) ? 1 : 0;
                    else          win = v0 ? 0 : 1;
                    e0 = v0 && (win == 0);
                    e1 = v1 && (win == 1);
                end
                chk("grant", {126'd0, bif.req1_ready, bif.req0_ready}, {126'd0, e1, e0});
            end
            if (v0 && bif.req0_ready)      sb.push_back(model(d0, n0, 1'b0, cyc + 1));
            else if (v1 && bif.req1_ready) sb.push_back(model(d1, n1, 1'b1, cyc + 1));
        end
    end

    // Monitor: unit traffic, busy, latency and result against the queue head.
    always @(negedge clk) begin
        logic  have;
        int    k;
        item_t f;
        #1;
        if (rst) begin
            sb.delete();
            last_id = -1;
        end else begin
            have = (sb.size() > 0) && (sb[0].acc <= cyc);
            k    = 0;
            if (have) begin
                f = sb[0];
                k = cyc - f.acc;
            end
            chk("busy", {127'd0, bif.busy}, {127'd0, have});
            chk("out_valid", {127'd0, bif.out_valid}, {127'd0, have && (k >= NW)});
            if (have && k < NW) begin
                chk("cu_a",   {112'd0, bif.cu_a},   {112'd0, f.op[16*k +: 16]});
                chk("cu_cin", {127'd0, bif.cu_cin}, {127'd0, cin_exp(f.op, f.neg, k)});
                chk("cu_cmp", {127'd0, bif.cu_cmp}, {127'd0, f.neg});
            end else begin
                chk("cu_idle", {110'd0, bif.cu_a, bif.cu_cin, bif.cu_cmp}, 128'd0);
            end
            if (have && bif.out_valid) begin
                chk("out_data", {64'd0, bif.out_data}, {64'd0, f.res});
                chk("out_flags", {125'd0, bif.out_id, bif.out_co, bif.out_ovf},
                                 {125'd0, f.id, f.co, f.ovf});
                if (bif.out_ready) begin
                    void'(sb.pop_front());
                    last_id = int'(f.id);
                end
            end
        end
    end

    task automatic push(input int id, input logic [W-1:0] op, input logic neg);
        stim_t s;
        s.op  = op;
        s.neg = neg;
        if (id == 0) q0.push_back(s);
        else         q1.push_back(s);
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return 64'h8000_0000_0000_0000;
            2:       return {48'd0, 16'($urandom)};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || v0 || v1 || sb.size() > 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (q0.size() > 0 || q1.size() > 0 || v0 || v1 || sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results still pending after %0d cycles", sb.size(), budget);
        end
        @(negedge clk);
    endtask

    task automatic wait_accept(input int budget);
        int n;
        n = 0;
        while (sb.size() == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL accept_timeout: no acceptance within %0d cycles", budget);
        end
    endtask

    task automatic check_reset_outs(input string name);
        @(negedge clk);
        #2;
        chk(name, {39'd0, bif.out_valid, bif.out_data, bif.out_id, bif.out_co, bif.out_ovf,
                   bif.busy, bif.cu_a, bif.cu_cin, bif.cu_cmp, bif.req0_ready, bif.req1_ready},
            128'd0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_outs("reset_state");

        // directed cases
        push(0, 64'h0000_0000_0000_0001, 1'b1); drain(100);
        push(1, 64'h0,                   1'b1); drain(100);
        push(0, 64'h8000_0000_0000_0000, 1'b1); drain(100);
        push(1, 64'h1234_5678_9ABC_DEF0, 1'b0); drain(100);

        // both requesters continuously valid: grants must alternate
        for (int i = 0; i < 4; i++) begin
            push(0, rand_op(), 1'($urandom));
            push(1, rand_op(), 1'($urandom));
        end
        drain(200);

        // consumer stalls in DONE while both requesters wait
        rdy_mode = 0;
        push(0, rand_op(), 1'b1);
        wait_accept(50);
        push(0, rand_op(), 1'b1);
        push(1, rand_op(), 1'b0);
        repeat (NW + 1 + 5) @(posedge clk);
        rdy_mode = 1;
        drain(200);

        // reset while RUN: aborted op never reaches the output
        push(1, rand_op(), 1'b1);
        wait_accept(50);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_reset_outs("reset_in_run");

        // after reset req0 wins a contested grant again
        push(0, rand_op(), 1'b1);
        push(1, rand_op(), 1'b1);
        drain(200);

        // random traffic with random consumer back-pressure
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0:       push(0, rand_op(), 1'($urandom));
                1:       push(1, rand_op(), 1'($urandom));
                default: begin
                    push(0, rand_op(), 1'($urandom));
                    push(1, rand_op(), 1'($urandom));
                end
            endcase
            repeat ($urandom_range(0, 6)) @(posedge clk);
        end
        drain(3000);
        rdy_mode = 1;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
